// File: rtl/weight_fetch_sequencer.sv
// weight_fetch_sequencer
// Per-neuron controller that streams input samples against the neuron's weight
// memory. Each accepted sample issues one weight read; the sample waits in S1
// for the registered weight, then the {sample, weight} pair moves to S2 and is
// offered to the MAC with valid/ready backpressure. The pair carrying the last
// address of the vector is flagged, and done pulses on its handshake.
//
// State table
//   IDLE  | waiting for start; no samples accepted
//   RUN   | accepting samples, one weight read per accept
//   DRAIN | all samples accepted; waiting for the last pair to handshake
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin a vector (only honoured in IDLE)
//   x_in, x_valid, x_ready   input sample stream
//   ren, raddr, wdata        weight memory read port (1-cycle registered read)
//   pair_x, pair_w           sample/weight pair to the MAC
//   pair_valid, pair_ready   pair handshake
//   pair_last                marks the pair for address numWeight-1
//   busy                     not IDLE
//   done                     one-cycle pulse on the last pair handshake
module weight_fetch_sequencer #(
    parameter int numWeight    = 784,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [dataWidth-1:0]  x_in,
    input  logic                  x_valid,
    output logic                  x_ready,
    output logic                  ren,
    output logic [addressWidth:0] raddr,
    input  logic [dataWidth-1:0]  wdata,
    output logic [dataWidth-1:0]  pair_x,
    output logic [dataWidth-1:0]  pair_w,
    output logic                  pair_valid,
    input  logic                  pair_ready,
    output logic                  pair_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [addressWidth:0] CNT_LAST = (addressWidth+1)'(numWeight - 1);
    localparam logic [addressWidth:0] CNT_END  = (addressWidth+1)'(numWeight);

    state_t                state;
    state_t                state_next;
    logic [addressWidth:0] cnt;

    logic                  s1_valid;
    logic                  s1_last;
    logic [dataWidth-1:0]  s1_x;

    logic                  s2_free;
    logic                  s1_move;
    logic                  accept;
    logic                  cnt_is_last;
    logic                  last_hs;

    // S2 can take a new pair if it is empty or its pair leaves this cycle.
    assign s2_free     = !pair_valid || pair_ready;
    assign s1_move     = s1_valid && s2_free;
    assign accept      = x_valid && x_ready;
    assign cnt_is_last = (cnt == CNT_LAST);
    assign last_hs     = pair_valid && pair_ready && pair_last;
    assign raddr       = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (accept && cnt_is_last) state_next = DRAIN;
            DRAIN:   if (last_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ren is only raised on an accept so wdata holds while S1 stalls.
    always_comb begin
        x_ready = (state == RUN) && (cnt < CNT_END) && (!s1_valid || s2_free);
        ren     = x_valid && x_ready;
        busy    = (state != IDLE);
        done    = (state == DRAIN) && last_hs;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_x       <= '0;
            pair_valid <= 1'b0;
            pair_last  <= 1'b0;
            pair_x     <= '0;
            pair_w     <= '0;
        end else begin
            if (state == IDLE && start) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= cnt + 1'b1;
            end

            // A refill in the same cycle as the S1->S2 move keeps full rate.
            if (accept) begin
                s1_x     <= x_in;
                s1_last  <= cnt_is_last;
                s1_valid <= 1'b1;
            end else if (s1_move) begin
                s1_valid <= 1'b0;
            end

            if (s1_move) begin
                pair_x     <= s1_x;
                pair_w     <= wdata;
                pair_last  <= s1_last;
                pair_valid <= 1'b1;
            end else if (pair_ready) begin
                pair_valid <= 1'b0;
            end
        end
    end

endmodule
